vga_text_timing: RTL and testbench

Parametrised VGA timing and text-cell address generator for the NPC display path. It generates horizontal and vertical counters, sync pulses and active-area pixel coordinates. It also produces character-cell column/row and the glyph offsets inside each cell, which drive the VRAM and font-ROM lookup. Sync, valid and colour are delayed by a configurable pipeline depth so they line up with the glyph bit returned by the downstream lookup chain.

---
 rtl/vga_text_timing_if.sv | 56 +++++
 rtl/vga_text_timing.sv | 301 ++++++++++++++++++++++++++++++
 tb/tb_vga_text_timing.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_text_timing_if.sv
`default_nettype none
// ============================================================================
//  Module      : vga_text_timing_if
//  Description : Bundle of the text-mode VGA timing signals. The generator
//                side (master) receives the glyph bit and cursor position
//                and drives pixel/cell addresses, sync, valid and colour.
//                The consumer side (slave) is the VRAM/font lookup plus the
//                DAC.
//  Signals     : pix_in      glyph bit for the pixel addressed PIPE cycles ago
//                cursor_col  cursor cell column
//                cursor_row  cursor cell row
//                h_addr      active pixel x (0 outside active area)
//                v_addr      active pixel y (0 outside active area)
//                col, row    character cell coordinate
//                gx, gy      pixel offset inside the cell
//                cell_valid  address stage is inside active area and grid
//                frame_start one-cycle pulse at pixel (0,0)
//                hsync/vsync delayed sync outputs
//                valid       delayed active-video flag
//                vga_r/g/b   colour outputs
//  Revision    : 1.0 - initial release
// ============================================================================
interface vga_text_timing_if;
    logic       pix_in;
    logic [6:0] cursor_col;
    logic [4:0] cursor_row;
    logic [9:0] h_addr;
    logic [9:0] v_addr;
    logic [6:0] col;
    logic [4:0] row;
    logic [3:0] gx;
    logic [3:0] gy;
    logic       cell_valid;
    logic       frame_start;
    logic       hsync;
    logic       vsync;
    logic       valid;
    logic [7:0] vga_r;
    logic [7:0] vga_g;
    logic [7:0] vga_b;

    // Timing generator side
    modport master (
        input  pix_in, cursor_col, cursor_row,
        output h_addr, v_addr, col, row, gx, gy, cell_valid, frame_start,
        output hsync, vsync, valid, vga_r, vga_g, vga_b
    );

    // Lookup chain / display side
    modport slave (
        output pix_in, cursor_col, cursor_row,
        input  h_addr, v_addr, col, row, gx, gy, cell_valid, frame_start,
        input  hsync, vsync, valid, vga_r, vga_g, vga_b
    );
endinterface
`default_nettype wire

// File: rtl/vga_text_timing.sv
`default_nettype none
// ============================================================================
//  Module      : vga_text_timing
//  Description : Parametrised VGA timing and text-cell address generator.
//                Stage 0 registers the pixel counters, active-area pixel
//                address, character cell column/row and glyph offsets that
//                drive the VRAM/font lookup. Sync, active, cell-valid and the
//                cursor hit travel down a PIPE-deep delay line so that they
//                meet the glyph bit (pix_in) returned by the lookup chain.
//  Ports       : pclk   - pixel clock
//                reset  - asynchronous, active-low reset
//                bus    - vga_text_timing_if.master (addresses, sync, colour,
//                         glyph bit and cursor position)
//  Options     : VGA_CURSOR_EN - when defined, builds the blinking block
//                cursor (frame counter + blink phase). When undefined the
//                cursor inputs are ignored and no cursor is drawn.
//  Revision    : 1.0 - initial release
// ============================================================================
module vga_text_timing #(
    parameter int          H_ACTIVE     = 640,
    parameter int          H_FP         = 16,
    parameter int          H_SYNC       = 96,
    parameter int          H_BP         = 48,
    parameter int          V_ACTIVE     = 480,
    parameter int          V_FP         = 10,
    parameter int          V_SYNC       = 2,
    parameter int          V_BP         = 33,
    parameter logic        HS_POL       = 1'b0,
    parameter logic        VS_POL       = 1'b0,
    parameter int          CHAR_W       = 9,     // 1..16
    parameter int          CHAR_H       = 16,    // 1..16
    parameter int          COLS         = 70,
    parameter int          ROWS         = 30,
    parameter int          PIPE         = 2,     // 1..4
    parameter logic [23:0] FG           = 24'hFFFFFF,
    parameter logic [23:0] BG           = 24'h000000,
    parameter int          BLINK_FRAMES = 32
) (
    input  wire logic           pclk,
    input  wire logic           reset,
    vga_text_timing_if.master   bus
);

    // ------------------------------------------------------------------------
    // Constants (12-bit counters cover any practical VGA mode)
    // ------------------------------------------------------------------------
    localparam logic [11:0] c_h_total     = 12'(H_ACTIVE + H_FP + H_SYNC + H_BP);
    localparam logic [11:0] c_v_total     = 12'(V_ACTIVE + V_FP + V_SYNC + V_BP);
    localparam logic [11:0] c_h_active    = 12'(H_ACTIVE);
    localparam logic [11:0] c_v_active    = 12'(V_ACTIVE);
    localparam logic [11:0] c_h_last      = 12'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [11:0] c_v_last      = 12'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [11:0] c_h_act_last  = 12'(H_ACTIVE - 1);
    localparam logic [11:0] c_hs_start    = 12'(H_ACTIVE + H_FP);
    localparam logic [11:0] c_hs_end      = 12'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [11:0] c_vs_start    = 12'(V_ACTIVE + V_FP);
    localparam logic [11:0] c_vs_end      = 12'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [3:0]  c_gx_last     = 4'(CHAR_W - 1);
    localparam logic [3:0]  c_gy_last     = 4'(CHAR_H - 1);
    localparam logic [7:0]  c_cols        = 8'(COLS);
    localparam logic [5:0]  c_rows        = 6'(ROWS);
    localparam logic [6:0]  c_col_max     = 7'd127;
    localparam logic [4:0]  c_row_max     = 5'd31;

    // Delay-line bit positions
    localparam int          c_b_hs        = 4;
    localparam int          c_b_vs        = 3;
    localparam int          c_b_act       = 2;
    localparam int          c_b_cv        = 1;
    localparam int          c_b_hit       = 0;

    // ------------------------------------------------------------------------
    // Stage 0 registers
    // ------------------------------------------------------------------------
    logic        r_run;           // 0 only on the first edge after reset
    logic [11:0] r_hcnt;
    logic [11:0] r_vcnt;
    logic [9:0]  r_h_addr;
    logic [9:0]  r_v_addr;
    logic [6:0]  r_col;
    logic [4:0]  r_row;
    logic [3:0]  r_gx;
    logic [3:0]  r_gy;
    logic        r_cell_valid;
    logic        r_frame_start;
    logic        r_hs_raw;
    logic        r_vs_raw;
    logic        r_active;

    logic [PIPE-1:0][4:0] r_pipe;

    // Next-state values; every stage-0 output is a registered function of
    // the counter value it will sit beside, so addresses and counters move
    // together.
    logic [11:0] w_h_nxt;
    logic [11:0] w_v_nxt;
    logic        w_act_nxt;
    logic        w_hs_nxt;
    logic        w_vs_nxt;
    logic [6:0]  w_col_nxt;
    logic [3:0]  w_gx_nxt;
    logic [4:0]  w_row_nxt;
    logic [3:0]  w_gy_nxt;
    logic        w_cv_nxt;
    logic        w_cursor_hit;

    // ------------------------------------------------------------------------
    // Pixel counters. The first edge after reset holds (0,0) so that pixel
    // (0,0) and its frame_start pulse are the first cycle seen after release.
    // ------------------------------------------------------------------------
    always_comb begin
        w_h_nxt = '0;
        w_v_nxt = '0;
        if (r_run) begin
            if (r_hcnt == c_h_last) begin
                w_h_nxt = '0;
                w_v_nxt = (r_vcnt == c_v_last) ? 12'd0 : r_vcnt + 12'd1;
            end else begin
                w_h_nxt = r_hcnt + 12'd1;
                w_v_nxt = r_vcnt;
            end
        end
    end

    assign w_act_nxt = (w_h_nxt < c_h_active) && (w_v_nxt < c_v_active);
    assign w_hs_nxt  = (w_h_nxt >= c_hs_start) && (w_h_nxt < c_hs_end);
    assign w_vs_nxt  = (w_v_nxt >= c_vs_start) && (w_v_nxt < c_vs_end);

    // ------------------------------------------------------------------------
    // Horizontal cell counters: gx steps on each active pixel, col steps when
    // gx wraps. Both restart at the beginning of every line.
    // ------------------------------------------------------------------------
    always_comb begin
        w_gx_nxt  = r_gx;
        w_col_nxt = r_col;
        if (w_h_nxt == 12'd0) begin
            w_gx_nxt  = '0;
            w_col_nxt = '0;
        end else if (w_h_nxt < c_h_active) begin
            if (r_gx == c_gx_last) begin
                w_gx_nxt = '0;
                if (r_col != c_col_max) begin
                    w_col_nxt = r_col + 7'd1;
                end
            end else begin
                w_gx_nxt = r_gx + 4'd1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Vertical cell counters: step once per active line when its last active
    // pixel is left, and restart at the top of every frame.
    // ------------------------------------------------------------------------
    always_comb begin
        w_gy_nxt  = r_gy;
        w_row_nxt = r_row;
        if ((w_h_nxt == 12'd0) && (w_v_nxt == 12'd0)) begin
            w_gy_nxt  = '0;
            w_row_nxt = '0;
        end else if (r_run && (r_hcnt == c_h_act_last) && (r_vcnt < c_v_active)) begin
            if (r_gy == c_gy_last) begin
                w_gy_nxt = '0;
                if (r_row != c_row_max) begin
                    w_row_nxt = r_row + 5'd1;
                end
            end else begin
                w_gy_nxt = r_gy + 4'd1;
            end
        end
    end

    assign w_cv_nxt = w_act_nxt
                   && ({1'b0, w_col_nxt} < c_cols)
                   && ({1'b0, w_row_nxt} < c_rows);

    // ------------------------------------------------------------------------
    // Stage 0 register bank
    // ------------------------------------------------------------------------
    always_ff @(posedge pclk or negedge reset) begin
        if (!reset) begin
            r_run         <= 1'b0;
            r_hcnt        <= '0;
            r_vcnt        <= '0;
            r_h_addr      <= '0;
            r_v_addr      <= '0;
            r_col         <= '0;
            r_row         <= '0;
            r_gx          <= '0;
            r_gy          <= '0;
            r_cell_valid  <= 1'b0;
            r_frame_start <= 1'b0;
            r_hs_raw      <= 1'b0;
            r_vs_raw      <= 1'b0;
            r_active      <= 1'b0;
        end else begin
            r_run         <= 1'b1;
            r_hcnt        <= w_h_nxt;
            r_vcnt        <= w_v_nxt;
            r_h_addr      <= w_act_nxt ? w_h_nxt[9:0] : 10'd0;
            r_v_addr      <= w_act_nxt ? w_v_nxt[9:0] : 10'd0;
            r_col         <= w_col_nxt;
            r_row         <= w_row_nxt;
            r_gx          <= w_gx_nxt;
            r_gy          <= w_gy_nxt;
            r_cell_valid  <= w_cv_nxt;
            r_frame_start <= (w_h_nxt == 12'd0) && (w_v_nxt == 12'd0);
            r_hs_raw      <= w_hs_nxt;
            r_vs_raw      <= w_vs_nxt;
            r_active      <= w_act_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Cursor. The hit is formed combinationally from the stage-0 cell and the
    // live cursor inputs, so a cursor move applies to the very next pixel
    // captured into the delay line.
    // ------------------------------------------------------------------------
`ifdef VGA_CURSOR_EN
    localparam int                 c_bf_w         = $clog2(BLINK_FRAMES + 1);
    localparam logic [c_bf_w-1:0]  c_blink_frames = c_bf_w'(BLINK_FRAMES);

    logic              r_blink;
    logic [c_bf_w-1:0] r_frame_cnt;

    // The pulse that completes a half-period also opens the next one, which
    // is why the counter restarts at 1 rather than 0.
    always_ff @(posedge pclk or negedge reset) begin
        if (!reset) begin
            r_blink     <= 1'b1;
            r_frame_cnt <= '0;
        end else if (r_frame_start) begin
            if (r_frame_cnt == c_blink_frames) begin
                r_blink     <= ~r_blink;
                r_frame_cnt <= c_bf_w'(1);
            end else begin
                r_frame_cnt <= r_frame_cnt + c_bf_w'(1);
            end
        end
    end

    assign w_cursor_hit = r_cell_valid
                       && (r_col == bus.cursor_col)
                       && (r_row == bus.cursor_row)
                       && r_blink;
`else
    logic w_unused_cursor;
    assign w_unused_cursor = &{1'b0, bus.cursor_col, bus.cursor_row};
    assign w_cursor_hit    = 1'b0;
`endif

    // ------------------------------------------------------------------------
    // Delay line: the last tap lines up with pix_in for the same pixel.
    // ------------------------------------------------------------------------
    always_ff @(posedge pclk or negedge reset) begin
        if (!reset) begin
            r_pipe <= '0;
        end else begin
            r_pipe[0] <= {r_hs_raw, r_vs_raw, r_active, r_cell_valid, w_cursor_hit};
            for (int i = PIPE - 1; i > 0; i--) begin
                r_pipe[i] <= r_pipe[i-1];
            end
        end
    end

    logic [4:0]  w_tap;
    logic [23:0] w_rgb;

    assign w_tap = r_pipe[PIPE-1];

    always_comb begin
        w_rgb = 24'h000000;
        if (w_tap[c_b_act]) begin
            if (!w_tap[c_b_cv]) begin
                w_rgb = BG;
            end else begin
                w_rgb = (bus.pix_in ^ w_tap[c_b_hit]) ? FG : BG;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign bus.h_addr      = r_h_addr;
    assign bus.v_addr      = r_v_addr;
    assign bus.col         = r_col;
    assign bus.row         = r_row;
    assign bus.gx          = r_gx;
    assign bus.gy          = r_gy;
    assign bus.cell_valid  = r_cell_valid;
    assign bus.frame_start = r_frame_start;
    assign bus.hsync       = w_tap[c_b_hs] ? HS_POL : ~HS_POL;
    assign bus.vsync       = w_tap[c_b_vs] ? VS_POL : ~VS_POL;
    assign bus.valid       = w_tap[c_b_act];
    assign bus.vga_r       = w_rgb[23:16];
    assign bus.vga_g       = w_rgb[15:8];
    assign bus.vga_b       = w_rgb[7:0];

endmodule
`default_nettype wire

// File: tb/tb_vga_text_timing.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vga_text_timing
//  Description : Self-checking bench for vga_text_timing. A reduced-size
//                instance (small mode, PIPE=3, inverted hsync polarity,
//                distinct colours, short blink) is checked cycle by cycle
//                against a reference model through a scoreboard queue. A
//                default-parameter instance is checked at selected cycles
//                of the first lines from a vector table.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_text_timing;

    // Reduced mode for the scoreboarded instance
    localparam int          S_HA    = 40;
    localparam int          S_HFP   = 4;
    localparam int          S_HS    = 6;
    localparam int          S_HBP   = 4;
    localparam int          S_VA    = 20;
    localparam int          S_VFP   = 2;
    localparam int          S_VS    = 2;
    localparam int          S_VBP   = 3;
    localparam int          S_CW    = 9;
    localparam int          S_CH    = 8;
    localparam int          S_COLS  = 4;
    localparam int          S_ROWS  = 2;
    localparam int          S_PIPE  = 3;
    localparam int          S_BF    = 2;
    localparam logic        S_HPOL  = 1'b1;
    localparam logic        S_VPOL  = 1'b0;
    localparam logic [23:0] S_FG    = 24'h12A5C3;
    localparam logic [23:0] S_BG    = 24'h3C0F81;
    localparam int          S_HT    = S_HA + S_HFP + S_HS + S_HBP;
    localparam int          S_VT    = S_VA + S_VFP + S_VS + S_VBP;
    localparam int          S_FRAME = S_HT * S_VT;

    logic pclk;
    logic reset;

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    vga_text_timing_if bus_s();
    vga_text_timing_if bus_d();

    vga_text_timing #(
        .H_ACTIVE(S_HA), .H_FP(S_HFP), .H_SYNC(S_HS), .H_BP(S_HBP),
        .V_ACTIVE(S_VA), .V_FP(S_VFP), .V_SYNC(S_VS), .V_BP(S_VBP),
        .HS_POL(S_HPOL), .VS_POL(S_VPOL),
        .CHAR_W(S_CW), .CHAR_H(S_CH), .COLS(S_COLS), .ROWS(S_ROWS),
        .PIPE(S_PIPE), .FG(S_FG), .BG(S_BG), .BLINK_FRAMES(S_BF)
    ) dut_s (
        .pclk  (pclk),
        .reset (reset),
        .bus   (bus_s)
    );

    vga_text_timing dut_d (
        .pclk  (pclk),
        .reset (reset),
        .bus   (bus_d)
    );

    // ------------------------------------------------------------------------
    // Bookkeeping
    // ------------------------------------------------------------------------
    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // ------------------------------------------------------------------------
    // Scoreboard for the reduced instance
    // ------------------------------------------------------------------------
    typedef struct {
        int   x;
        int   y;
        logic act;
        logic cv;
        logic hit;
        logic hs;
        logic vs;
    } pix_t;

    pix_t sbq[$];
    int   t;        // cycle index since reset release
    int   cur_c;    // cursor position applied at the next step
    int   cur_r;

    function automatic logic glyph(input int x, input int y);
        return (((x * 5) + (y * 3) + (x >> 2)) % 3) == 0;
    endfunction

    task automatic sb_restart();
        pix_t blank;
        blank = '{x: 0, y: 0, act: 1'b0, cv: 1'b0, hit: 1'b0, hs: 1'b0, vs: 1'b0};
        sbq.delete();
        for (int i = 0; i < S_PIPE; i++) sbq.push_back(blank);
        t = 0;
    endtask

    task automatic step();
        int          x, y, f;
        logic        blink, pix;
        pix_t        e, d;
        logic [9:0]  e_h, e_v;
        logic [6:0]  e_col;
        logic [3:0]  e_gx, e_gy;
        logic [4:0]  e_row;
        logic [23:0] e_rgb;
        logic        e_fs;

        @(posedge pclk);
        #1;
        bus_s.cursor_col = 7'(cur_c);
        bus_s.cursor_row = 5'(cur_r);

        x = t % S_HT;
        y = (t / S_HT) % S_VT;
        f = t / S_FRAME;
        blink = ((f / S_BF) % 2) == 0;

        e.x   = x;
        e.y   = y;
        e.act = (x < S_HA) && (y < S_VA);
        e.cv  = e.act && ((x / S_CW) < S_COLS) && ((y / S_CH) < S_ROWS);
`ifdef VGA_CURSOR_EN
        e.hit = e.cv && ((x / S_CW) == cur_c) && ((y / S_CH) == cur_r) && blink;
`else
        e.hit = 1'b0;
`endif
        e.hs  = (x >= S_HA + S_HFP) && (x < S_HA + S_HFP + S_HS);
        e.vs  = (y >= S_VA + S_VFP) && (y < S_VA + S_VFP + S_VS);

        e_h  = e.act ? 10'(x) : 10'd0;
        e_v  = e.act ? 10'(y) : 10'd0;
        e_fs = (x == 0) && (y == 0);
        chk("s_stage0", 64'({bus_s.h_addr, bus_s.v_addr, bus_s.cell_valid, bus_s.frame_start}),
                        64'({e_h, e_v, e.cv, e_fs}));
        if (e.act) begin
            e_col = 7'(x / S_CW);
            e_gx  = 4'(x % S_CW);
            e_row = 5'(y / S_CH);
            e_gy  = 4'(y % S_CH);
            chk("s_cell", 64'({bus_s.col, bus_s.gx, bus_s.row, bus_s.gy}),
                          64'({e_col, e_gx, e_row, e_gy}));
        end

        sbq.push_back(e);
        d = sbq.pop_front();
        pix = d.act ? glyph(d.x, d.y) : 1'b0;
        bus_s.pix_in = pix;
        #1;
        if (!d.act)     e_rgb = 24'h000000;
        else if (!d.cv) e_rgb = S_BG;
        else            e_rgb = (pix ^ d.hit) ? S_FG : S_BG;
        chk("s_out", 64'({bus_s.valid, bus_s.hsync, bus_s.vsync, bus_s.vga_r, bus_s.vga_g, bus_s.vga_b}),
                     64'({d.act, d.hs ? S_HPOL : ~S_HPOL, d.vs ? S_VPOL : ~S_VPOL, e_rgb}));
        t++;
    endtask

    task automatic chk_reset_s(input string name);
        chk({name, "_stage0"},
            64'({bus_s.h_addr, bus_s.v_addr, bus_s.col, bus_s.row, bus_s.gx, bus_s.gy,
                 bus_s.cell_valid, bus_s.frame_start}), 64'd0);
        chk({name, "_out"},
            64'({bus_s.valid, bus_s.hsync, bus_s.vsync, bus_s.vga_r, bus_s.vga_g, bus_s.vga_b}),
            64'({1'b0, ~S_HPOL, ~S_VPOL, 24'h000000}));
    endtask

    // ------------------------------------------------------------------------
    // Vector table for the default-parameter instance (PIPE=2, pix_in=1)
    // ------------------------------------------------------------------------
    typedef struct {
        int          cyc;
        logic [9:0]  h;
        logic [9:0]  v;
        logic        cc;     // compare cell fields
        logic [6:0]  col;
        logic [3:0]  gx;
        logic [4:0]  row;
        logic [3:0]  gy;
        logic        cv;
        logic        fs;
        logic        hs;
        logic        vld;
        logic [23:0] rgb;
    } vec_t;

    function automatic vec_t mk(input int cyc, input int h, input int v, input logic cc,
                                input int col, input int gx, input int row, input int gy,
                                input logic cv, input logic fs, input logic hs,
                                input logic vld, input logic [23:0] rgb);
        vec_t r;
        r.cyc = cyc;     r.h  = 10'(h);  r.v   = 10'(v);   r.cc = cc;
        r.col = 7'(col); r.gx = 4'(gx);  r.row = 5'(row);  r.gy = 4'(gy);
        r.cv  = cv;      r.fs = fs;      r.hs  = hs;       r.vld = vld;
        r.rgb = rgb;
        return r;
    endfunction

    localparam int NV = 16;
    vec_t vecs[NV];

    // ------------------------------------------------------------------------
    // Test sequence
    // ------------------------------------------------------------------------
    initial begin
        //             cyc   h    v  cc col gx row gy cv fs hs vld rgb
        vecs[0]  = mk(   0,   0,  0, 1,  0, 0, 0, 0, 1, 1, 1, 0, 24'h000000);
        vecs[1]  = mk(   1,   1,  0, 1,  0, 1, 0, 0, 1, 0, 1, 0, 24'h000000);
        vecs[2]  = mk(   2,   2,  0, 1,  0, 2, 0, 0, 1, 0, 1, 1, 24'hFFFFFF);
        vecs[3]  = mk(   8,   8,  0, 1,  0, 8, 0, 0, 1, 0, 1, 1, 24'hFFFFFF);
        vecs[4]  = mk(   9,   9,  0, 1,  1, 0, 0, 0, 1, 0, 1, 1, 24'hFFFFFF);
        vecs[5]  = mk( 630, 630,  0, 1, 70, 0, 0, 0, 0, 0, 1, 1, 24'hFFFFFF);
        vecs[6]  = mk( 632, 632,  0, 1, 70, 2, 0, 0, 0, 0, 1, 1, 24'h000000);
        vecs[7]  = mk( 639, 639,  0, 1, 71, 0, 0, 0, 0, 0, 1, 1, 24'h000000);
        vecs[8]  = mk( 642,   0,  0, 0,  0, 0, 0, 0, 0, 0, 1, 0, 24'h000000);
        vecs[9]  = mk( 657,   0,  0, 0,  0, 0, 0, 0, 0, 0, 1, 0, 24'h000000);
        vecs[10] = mk( 658,   0,  0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 24'h000000);
        vecs[11] = mk( 753,   0,  0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 24'h000000);
        vecs[12] = mk( 754,   0,  0, 0,  0, 0, 0, 0, 0, 0, 1, 0, 24'h000000);
        vecs[13] = mk( 800,   0,  1, 1,  0, 0, 0, 1, 1, 0, 1, 0, 24'h000000);
        vecs[14] = mk( 802,   2,  1, 1,  0, 2, 0, 1, 1, 0, 1, 1, 24'hFFFFFF);
        vecs[15] = mk(1615,  15,  2, 1,  1, 6, 0, 2, 1, 0, 1, 1, 24'hFFFFFF);

        reset            = 1'b0;
        cur_c            = 1;
        cur_r            = 1;
        bus_s.pix_in     = 1'b0;
        bus_s.cursor_col = 7'd1;
        bus_s.cursor_row = 5'd1;
        bus_d.pix_in     = 1'b1;
        bus_d.cursor_col = 7'd3;
        bus_d.cursor_row = 5'd2;

        // Power-on reset values
        repeat (3) @(posedge pclk);
        @(negedge pclk);
        chk_reset_s("por");
        chk("por_d_out", 64'({bus_d.valid, bus_d.hsync, bus_d.vsync, bus_d.vga_r, bus_d.vga_g, bus_d.vga_b}),
                         64'({1'b0, 1'b1, 1'b1, 24'h000000}));

        reset = 1'b1;
        sb_restart();

        // Default-mode table, scoreboard running on the reduced instance
        for (int i = 0; i < NV; i++) begin
            while (t < vecs[i].cyc + 1) step();
            chk($sformatf("d_addr[%0d]", vecs[i].cyc),
                64'({bus_d.h_addr, bus_d.v_addr, bus_d.cell_valid, bus_d.frame_start}),
                64'({vecs[i].h, vecs[i].v, vecs[i].cv, vecs[i].fs}));
            if (vecs[i].cc) begin
                chk($sformatf("d_cell[%0d]", vecs[i].cyc),
                    64'({bus_d.col, bus_d.gx, bus_d.row, bus_d.gy}),
                    64'({vecs[i].col, vecs[i].gx, vecs[i].row, vecs[i].gy}));
            end
            chk($sformatf("d_out[%0d]", vecs[i].cyc),
                64'({bus_d.valid, bus_d.hsync, bus_d.vga_r, bus_d.vga_g, bus_d.vga_b}),
                64'({vecs[i].vld, vecs[i].hs, vecs[i].rgb}));
        end

        // Free run across blink phases; the cursor moves mid-line in frame 4
        while (t < 6 * S_FRAME) begin
            if (t == 4 * S_FRAME + 200) begin
                cur_c = 2;
                cur_r = 0;
            end
            step();
        end

        // Stop while the delayed hsync is asserted, then reset mid-line
        while (((t - 1 - S_PIPE) % S_HT) != 46) step();
        #1;
        reset = 1'b0;
        #1;
        chk_reset_s("midrst");
        repeat (2) @(posedge pclk);
        @(negedge pclk);
        chk_reset_s("midrst_hold");
        bus_s.pix_in = 1'b0;
        reset = 1'b1;
        sb_restart();
        cur_c = 3;
        cur_r = 1;
        while (t < S_FRAME + 100) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
